// File: rtl/alu_seq.sv
// Sequential ALU for the EX stage: single-cycle logic/arithmetic ops plus
// iterative shift-add multiply and restoring divide behind a start/busy/done handshake.
module alu_seq #(
    parameter int WIDTH = 32,
    parameter int SHW   = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       aluop,
    input  logic [WIDTH-1:0] data1,
    input  logic [WIDTH-1:0] data2,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             overflow,
    output logic             div_by_zero,
    output logic             busy,
    output logic             done
);

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_MUL  = 4'hC;
    localparam logic [3:0] OP_DIVU = 4'hD;
    localparam logic [3:0] OP_REMU = 4'hE;

    typedef enum logic {IDLE, ITER} state_t;

    state_t           state, state_nxt;
    logic [3:0]       op_q;
    logic [WIDTH-1:0] opa, opb, acc;
    logic [SHW-1:0]   cnt;

    // Single-cycle ops; divide-by-zero results are also resolved here.
    function automatic logic [WIDTH-1:0] alu_single(input logic [3:0] op,
                                                    input logic [WIDTH-1:0] a,
                                                    input logic [WIDTH-1:0] b);
        logic signed [WIDTH-1:0] sa;
        logic signed [WIDTH-1:0] sb;
        logic [SHW-1:0]          sh;
        logic [WIDTH-1:0]        res;
        sa = a;
        sb = b;
        sh = b[SHW-1:0];
        case (op)
            4'h0:    res = a + b;
            4'h1:    res = a - b;
            4'h2:    res = a | b;
            4'h3:    res = WIDTH'(a < b);
            4'h4:    res = a & b;
            4'h5:    res = a ^ b;
            4'h6:    res = ~(a | b);
            4'h7:    res = WIDTH'(sa < sb);
            4'h8:    res = a << sh;
            4'h9:    res = a >> sh;
            4'hA:    res = sa >>> sh;
            4'hB:    res = b << (WIDTH / 2);
            4'hD:    res = '1;
            default: res = a;
        endcase
        return res;
    endfunction

    function automatic logic add_sub_ovf(input logic [3:0] op,
                                         input logic [WIDTH-1:0] a,
                                         input logic [WIDTH-1:0] b,
                                         input logic [WIDTH-1:0] r);
        logic ovf;
        ovf = 1'b0;
        if (op == OP_ADD)
            ovf = (a[WIDTH-1] == b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
        else if (op == OP_SUB)
            ovf = (a[WIDTH-1] != b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
        return ovf;
    endfunction

    logic             is_div, is_iter;
    logic [WIDTH-1:0] res_c;
    logic             ovf_c;

    assign is_div  = (aluop == OP_DIVU) || (aluop == OP_REMU);
    assign is_iter = (aluop == OP_MUL) || (is_div && (data2 != '0));
    assign res_c   = alu_single(aluop, data1, data2);
    assign ovf_c   = add_sub_ovf(aluop, data1, data2, res_c);
    assign busy    = (state == ITER);

    // One iteration step: acc is the partial product (MUL) or partial remainder
    // (DIVU/REMU); for division opa shifts the dividend out and quotient bits in.
    logic [WIDTH:0]   div_t, div_d;
    logic             div_ge;
    logic [WIDTH-1:0] rem_step, quo_step, acc_step, fin;

    always_comb begin
        div_t    = {acc, opa[WIDTH-1]};
        div_d    = div_t - {1'b0, opb};
        div_ge   = ~div_d[WIDTH];
        rem_step = div_ge ? div_d[WIDTH-1:0] : div_t[WIDTH-1:0];
        quo_step = {opa[WIDTH-2:0], div_ge};
        acc_step = acc + (opb[0] ? opa : '0);
        if (op_q == OP_MUL)
            fin = acc_step;
        else if (op_q == OP_DIVU)
            fin = quo_step;
        else
            fin = rem_step;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start && is_iter) state_nxt = ITER;
            ITER:    if (cnt == '0) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q        <= '0;
            opa         <= '0;
            opb         <= '0;
            acc         <= '0;
            cnt         <= '0;
            result      <= '0;
            zero        <= 1'b0;
            overflow    <= 1'b0;
            div_by_zero <= 1'b0;
            done        <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == IDLE) begin
                if (start && is_iter) begin
                    op_q <= aluop;
                    opa  <= data1;
                    opb  <= data2;
                    acc  <= '0;
                    cnt  <= SHW'(WIDTH - 1);
                end else if (start) begin
                    result      <= res_c;
                    zero        <= (res_c == '0);
                    overflow    <= ovf_c;
                    div_by_zero <= is_div;
                    done        <= 1'b1;
                end
            end else begin
                if (op_q == OP_MUL) begin
                    acc <= acc_step;
                    opa <= opa << 1;
                    opb <= opb >> 1;
                end else begin
                    acc <= rem_step;
                    opa <= quo_step;
                end
                cnt <= cnt - SHW'(1);
                if (cnt == '0) begin
                    result      <= fin;
                    zero        <= (fin == '0);
                    overflow    <= 1'b0;
                    div_by_zero <= 1'b0;
                    done        <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq (WIDTH=32): stimulus queues hand-computed
// expectations, a monitor pops and compares on every done pulse.
module tb_alu_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [3:0]  aluop;
    logic [31:0] data1, data2;
    logic [31:0] result;
    logic        zero, overflow, div_by_zero, busy, done;

    int passed = 0;
    int total  = 0;
    int cyc    = 0;

    typedef struct {
        string       name;
        logic [31:0] res;
        logic        z;
        logic        ov;
        logic        dbz;
        int          due;
    } exp_t;

    exp_t sbq[$];

    alu_seq #(.WIDTH(32), .SHW(5)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .aluop(aluop),
        .data1(data1), .data2(data2), .result(result), .zero(zero),
        .overflow(overflow), .div_by_zero(div_by_zero), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        total++;
        if (act === expv) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
    endtask

    // Monitor: every done must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            check("busy_done_exclusive", 64'(busy & done), 64'd0);
            if (done) begin
                if (sbq.size() == 0) begin
                    total++;
                    $display("FAIL unexpected_done: got done with result 0x%0h, expected no done", result);
                end else begin
                    e = sbq.pop_front();
                    check({e.name, ".result"}, 64'(result), 64'(e.res));
                    check({e.name, ".flags"}, 64'({zero, overflow, div_by_zero}), 64'({e.z, e.ov, e.dbz}));
                    check({e.name, ".cycle"}, 64'(cyc), 64'(e.due));
                end
            end
        end
    end

    // Drives one request at the current negedge; lat = edges from sampling edge to done.
    task automatic issue(input string name, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] r, input logic ov,
                         input logic dbz, input int lat, input bit expect_done);
        exp_t e;
        start = 1'b1;
        aluop = op;
        data1 = a;
        data2 = b;
        if (expect_done) begin
            e.name = name; e.res = r; e.z = (r == 32'd0); e.ov = ov; e.dbz = dbz;
            e.due = cyc + 1 + lat;
            sbq.push_back(e);
        end
        @(negedge clk);
        start = 1'b0;
        aluop = 4'($urandom);
        data1 = $urandom;
        data2 = $urandom;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 100 && sbq.size() > 0; i++) @(negedge clk);
        if (sbq.size() > 0) begin
            total++;
            $display("FAIL %s.timeout: got %0d outstanding, expected 0", name, sbq.size());
            sbq.delete();
        end
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (!done && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!done) begin
            total++;
            $display("FAIL %s.wait_done: got no done, expected done within 100 cycles", name);
        end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; aluop = 4'h0; data1 = '0; data2 = '0;
        #12;
        check("reset_state", 64'({result, zero, overflow, div_by_zero, busy, done}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        issue("add_ovf",  4'h0, 32'h7FFFFFFF, 32'h1, 32'h80000000, 1'b1, 1'b0, 0, 1); drain("add_ovf");
        issue("sub_zero", 4'h1, 32'd5, 32'd5, 32'h0, 1'b0, 1'b0, 0, 1);               drain("sub_zero");
        issue("sub_ovf",  4'h1, 32'h80000000, 32'h1, 32'h7FFFFFFF, 1'b1, 1'b0, 0, 1); drain("sub_ovf");
        issue("slt",      4'h7, 32'hFFFFFFFF, 32'h1, 32'h1, 1'b0, 1'b0, 0, 1);        drain("slt");
        issue("sltu",     4'h3, 32'hFFFFFFFF, 32'h1, 32'h0, 1'b0, 1'b0, 0, 1);        drain("sltu");
        issue("or",       4'h2, 32'hF0, 32'h0F, 32'hFF, 1'b0, 1'b0, 0, 1);            drain("or");
        issue("and",      4'h4, 32'hF0, 32'h0F, 32'h0, 1'b0, 1'b0, 0, 1);             drain("and");
        issue("xor",      4'h5, 32'hA5A5, 32'hFFFF, 32'h5A5A, 1'b0, 1'b0, 0, 1);      drain("xor");
        issue("nor",      4'h6, 32'h0, 32'h0, 32'hFFFFFFFF, 1'b0, 1'b0, 0, 1);        drain("nor");
        issue("sll",      4'h8, 32'h1, 32'd31, 32'h80000000, 1'b0, 1'b0, 0, 1);       drain("sll");
        issue("sll_mask", 4'h8, 32'h1, 32'h21, 32'h2, 1'b0, 1'b0, 0, 1);             drain("sll_mask");
        issue("srl",      4'h9, 32'h80000000, 32'd4, 32'h08000000, 1'b0, 1'b0, 0, 1); drain("srl");
        issue("lui",      4'hB, 32'h0, 32'h1234, 32'h12340000, 1'b0, 1'b0, 0, 1);     drain("lui");
        issue("pass",     4'hF, 32'hDEADBEEF, 32'h0, 32'hDEADBEEF, 1'b0, 1'b0, 0, 1); drain("pass");

        issue("mul",      4'hC, 32'h00010001, 32'h00010001, 32'h00020001, 1'b0, 1'b0, 32, 1);
        check("mul.busy", 64'(busy), 64'd1);
        drain("mul");
        issue("mul_ones", 4'hC, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h1, 1'b0, 1'b0, 32, 1); drain("mul_ones");
        issue("divu",     4'hD, 32'd100, 32'd7, 32'd14, 1'b0, 1'b0, 32, 1);
        check("divu.busy", 64'(busy), 64'd1);
        drain("divu");
        issue("remu",     4'hE, 32'd100, 32'd7, 32'd2, 1'b0, 1'b0, 32, 1);            drain("remu");
        issue("divu_big", 4'hD, 32'hFFFFFFFF, 32'h1, 32'hFFFFFFFF, 1'b0, 1'b0, 32, 1); drain("divu_big");
        issue("remu_16",  4'hE, 32'hFFFFFFFF, 32'h10, 32'hF, 1'b0, 1'b0, 32, 1);      drain("remu_16");
        issue("divu_by0", 4'hD, 32'd9, 32'd0, 32'hFFFFFFFF, 1'b0, 1'b1, 0, 1);        drain("divu_by0");
        issue("remu_by0", 4'hE, 32'd9, 32'd0, 32'd9, 1'b0, 1'b1, 0, 1);              drain("remu_by0");

        // Start while busy is ignored; start in the done cycle is accepted.
        issue("mul_busy", 4'hC, 32'd3, 32'd5, 32'd15, 1'b0, 1'b0, 32, 1);
        repeat (5) @(negedge clk);
        issue("ignored_add", 4'h0, 32'd1, 32'd1, 32'd2, 1'b0, 1'b0, 0, 0);
        wait_done("mul_busy");
        issue("b2b_add",  4'h0, 32'd2, 32'd3, 32'd5, 1'b0, 1'b0, 0, 1);
        drain("b2b_add");

        // Asynchronous reset mid-divide: outputs clear at once and no done follows.
        issue("divu_abort", 4'hD, 32'd1000, 32'd3, 32'd333, 1'b0, 1'b0, 32, 0);
        repeat (9) @(negedge clk);
        check("abort.busy_before", 64'(busy), 64'd1);
        #2 rst_n = 1'b0;
        #1 check("abort.outputs", 64'({result, zero, overflow, div_by_zero, busy, done}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        issue("sra",      4'hA, 32'h80000000, 32'd4, 32'hF8000000, 1'b0, 1'b0, 0, 1); drain("sra");

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
